pcd8544_spi_tx: RTL

Byte-level SPI transmitter for the PCD8544 (Nokia 5110) LCD. It sits directly downstream of the screen configuration/drawing sequencer. It accepts one byte plus a data/command flag per transfer, serialises it MSB-first onto `mosi`/`sclk` with `sce` and `dc` framing, and generates the LCD power-on reset pulse on `rst`. A one-cycle `avail` pulse tells the sequencer when to present the next byte.

---
 rtl/pcd8544_spi_tx_pkg.sv | 32 +++
 rtl/pcd8544_spi_tx_spi_half_period_timer.sv | 41 ++++
 rtl/pcd8544_spi_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pcd8544_spi_tx_pkg.sv
//==============================================================================
// pcd8544_spi_tx_pkg : shared FSM encoding and PCD8544 command bytes (rev 1.0)
//==============================================================================
`default_nettype none

package pcd8544_spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_LCD_RST = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SCK_LO  = 3'd3,
    ST_SCK_HI  = 3'd4,
    ST_DONE    = 3'd5,
    ST_GUARD   = 3'd6
  } state_t;

  // Command bytes issued by the upstream configuration/drawing sequencer
  localparam logic [7:0] c_LCD_FUNC_EXTENDED = 8'h21;
  localparam logic [7:0] c_LCD_SET_VOP       = 8'h90;
  localparam logic [7:0] c_LCD_FUNC_BASIC    = 8'h20;
  localparam logic [7:0] c_LCD_DISP_NORMAL   = 8'h0C;
  localparam logic [7:0] c_LCD_SET_X_BASE    = 8'h80;
  localparam logic [7:0] c_LCD_SET_Y_BASE    = 8'h40;

  function automatic logic [15:0] half_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcd8544_spi_tx_spi_half_period_timer.sv
//==============================================================================
// spi_half_period_timer : free-running half-period counter, ticks at D-1 (rev 1.0)
//==============================================================================
`default_nettype none

module spi_half_period_timer
  import pcd8544_spi_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic [15:0] i_div_factor,
  output logic        o_tick
);

  logic [15:0] w_limit;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // >= rather than == so a mid-byte shrink of div_factor cannot strand the count
  assign w_limit = half_period(i_div_factor) - 16'd1;
  assign o_tick  = (cnt_q >= w_limit);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (i_clear || o_tick) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcd8544_spi_tx.sv
//==============================================================================
// pcd8544_spi_tx : byte-level SPI transmitter and reset generator for PCD8544 (rev 1.0)
//==============================================================================
`default_nettype none

module pcd8544_spi_tx
  import pcd8544_spi_tx_pkg::*;
#(
  parameter int RST_CYCLES   = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [7:0]  data_in,
  input  logic        start,
  input  logic        command,
  input  logic [15:0] div_factor,
  output logic        mosi,
  output logic        sclk,
  output logic        sce,
  output logic        dc,
  output logic        rst,
  output logic        busy,
  output logic        avail
);

  localparam int RST_W   = $clog2(RST_CYCLES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  state_t               state_q,     state_d;
  logic [6:0]           shreg_q,     shreg_d;
  logic [2:0]           bit_cnt_q,   bit_cnt_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [RST_W-1:0]     rst_cnt_q,   rst_cnt_d;
  logic                 mosi_q,  mosi_d;
  logic                 sclk_q,  sclk_d;
  logic                 sce_q,   sce_d;
  logic                 dc_q,    dc_d;
  logic                 rst_q,   rst_d;
  logic                 busy_q,  busy_d;
  logic                 avail_q, avail_d;
  logic                 w_timer_clear;
  logic                 w_tick;

  spi_half_period_timer u_timer (
    .clk          (clock),
    .rst_n        (Reset),
    .i_clear      (w_timer_clear),
    .i_div_factor (div_factor),
    .o_tick       (w_tick)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    rst_cnt_d     = rst_cnt_q;
    mosi_d        = mosi_q;
    sclk_d        = sclk_q;
    sce_d         = sce_q;
    dc_d          = dc_q;
    rst_d         = rst_q;
    avail_d       = 1'b0;
    w_timer_clear = 1'b1;

    case (state_q)
      ST_LCD_RST: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          rst_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        sce_d  = 1'b1;
        sclk_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shreg_d   = data_in[6:0];
        mosi_d    = data_in[7];
        dc_d      = command;
        sce_d     = 1'b0;
        bit_cnt_d = 3'd0;
        state_d   = ST_SCK_LO;
      end
      ST_SCK_LO: begin
        w_timer_clear = 1'b0;
        if (w_tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        w_timer_clear = 1'b0;
        if (w_tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            avail_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Next bit goes out on the falling edge so it is settled before the rise
            mosi_d    = shreg_q[6];
            shreg_d   = {shreg_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = ST_SCK_LO;
          end
        end
      end
      ST_DONE: begin
        guard_cnt_d = '0;
        state_d     = ST_GUARD;
      end
      ST_GUARD: begin
        guard_cnt_d = guard_cnt_q + GUARD_W'(1);
        if (guard_cnt_q == GUARD_W'(GUARD_CYCLES - 1)) begin
          if (start) begin
            state_d = ST_LOAD;
          end else begin
            sce_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_LCD_RST;
      end
    endcase

    // Held high through the whole LCD reset so busy drops one cycle after rst rises
    busy_d = (state_q == ST_LCD_RST) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_LCD_RST;
      shreg_q     <= 7'd0;
      bit_cnt_q   <= 3'd0;
      guard_cnt_q <= '0;
      rst_cnt_q   <= '0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sce_q       <= 1'b1;
      dc_q        <= 1'b0;
      rst_q       <= 1'b0;
      busy_q      <= 1'b1;
      avail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      sce_q       <= sce_d;
      dc_q        <= dc_d;
      rst_q       <= rst_d;
      busy_q      <= busy_d;
      avail_q     <= avail_d;
    end
  end

  assign mosi  = mosi_q;
  assign sclk  = sclk_q;
  assign sce   = sce_q;
  assign dc    = dc_q;
  assign rst   = rst_q;
  assign busy  = busy_q;
  assign avail = avail_q;

endmodule

`default_nettype wire
